// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and defaults for the UART receive sequencer.
package uart_rx_ctrl_pkg;

    localparam int DW        = 8;
    localparam int BIT_TICKS = 434;

    typedef logic [DW-1:0] data_t;
    typedef logic          bit_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    typedef struct packed {
        bit_t shift_enb;
        bit_t shift_bit;
        bit_t hold;
        bit_t rx_valid;
        bit_t frame_err;
        bit_t busy;
    } rx_out_t;

    localparam rx_out_t RX_OUT_RST = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/uart_rx_ctrl_baud_cnt.sv
// Modulo-TICKS counter with synchronous clear; flags the terminal and half-bit counts.
module uart_baud_cnt #(
    parameter int TICKS = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tc_o,
    output logic half_o
);

    localparam int             CW      = $clog2(TICKS);
    localparam logic [CW-1:0]  CNT_TC  = CW'(TICKS - 1);
    localparam logic [CW-1:0]  CNT_HLF = CW'(TICKS / 2 - 1);

    logic [CW-1:0] cnt_q;

    assign tc_o   = (cnt_q == CNT_TC);
    assign half_o = (cnt_q == CNT_HLF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i || tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sampling, shift-register control, stop-bit check.
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | qualifying start bit at half-bit point
//   DATA  | sampling DW data bits, one shift pulse each
//   STOP  | sampling stop bit, latch word or flag framing error
//   BREAK | line held low after framing error, wait for high
module uart_rx_ctrl #(
    parameter int DW        = uart_rx_ctrl_pkg::DW,
    parameter int BIT_TICKS = uart_rx_ctrl_pkg::BIT_TICKS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          rx_i,
    input  logic [DW-1:0] data_i,
    output logic          shift_enb_o,
    output logic          shift_bit_o,
    output logic          hold_o,
    output logic [DW-1:0] rx_data_o,
    output logic          rx_valid_o,
    output logic          frame_err_o,
    output logic          busy_o
);

    import uart_rx_ctrl_pkg::*;

    localparam int            BW       = $clog2(DW + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    logic          fall;
    rx_state_e     state_q;
    logic [BW-1:0] bit_cnt_q;
    rx_out_t       out_q;
    logic [DW-1:0] rx_data_q;
    logic          baud_clr;
    logic          baud_tc;
    logic          baud_half;

    assign rx_s = sync_q[1];
    assign fall = prev_q && !rx_s;

    // Counter is held at zero outside of a timed bit, so every entry into START begins at 0.
    assign baud_clr = !en_i || (state_q == IDLE) || (state_q == BREAK) ||
                      ((state_q == START) && baud_half);

    uart_baud_cnt #(
        .TICKS (BIT_TICKS)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (baud_clr),
        .tc_o   (baud_tc),
        .half_o (baud_half)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            out_q     <= RX_OUT_RST;
            rx_data_q <= '0;
        end else begin
            out_q.shift_enb <= 1'b0;
            out_q.rx_valid  <= 1'b0;
            out_q.frame_err <= 1'b0;
            if (!en_i) begin
                state_q    <= IDLE;
                out_q.hold <= 1'b1;
                out_q.busy <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fall) begin
                            state_q    <= START;
                            out_q.busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (baud_half) begin
                            if (!rx_s) begin
                                state_q    <= DATA;
                                bit_cnt_q  <= '0;
                                out_q.hold <= 1'b0;
                            end else begin
                                state_q    <= IDLE;
                                out_q.busy <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (baud_tc) begin
                            out_q.shift_enb <= 1'b1;
                            out_q.shift_bit <= rx_s;
                            bit_cnt_q       <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        // Hold rises one cycle into STOP so the last shift pulse still sees hold low.
                        out_q.hold <= 1'b1;
                        if (baud_tc) begin
                            out_q.busy <= 1'b0;
                            if (rx_s) begin
                                rx_data_q      <= data_i;
                                out_q.rx_valid <= 1'b1;
                                state_q        <= IDLE;
                            end else begin
                                out_q.frame_err <= 1'b1;
                                state_q         <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        out_q.hold <= 1'b1;
                        out_q.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign shift_enb_o = out_q.shift_enb;
    assign shift_bit_o = out_q.shift_bit;
    assign hold_o      = out_q.hold;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = out_q.rx_valid;
    assign frame_err_o = out_q.frame_err;
    assign busy_o      = out_q.busy;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART serial-in/parallel-out shift register.
- Synchronizes the asynchronous RX line and detects and qualifies the start bit.
- Times mid-bit sampling with a baud counter and drives the shift register's shift-enable, serial-bit and hold controls.
- Latches the completed word, checks the stop bit and reports valid or framing error.
- Sits between the RX pin and the shift register. Its outputs feed the UART receive FIFO and status logic.

Parameters:
- DW, 8: data bits per frame; equals the shift register width. LSB is received first.
- BIT_TICKS, 434: clk cycles per bit (50 MHz / 115200). Legal range ≥4; even values only.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- en_i  in  1  receiver enable; low aborts any frame in progress
- rx_i  in  1  asynchronous serial line; idles high
- data_i  in  DW  parallel word from the shift register
- shift_enb_o  out  1  shift register enable; one-cycle pulse per data bit
- shift_bit_o  out  1  sampled serial bit; valid while shift_enb_o is high
- hold_o  out  1  shift register hold (count-finished); freezes the register when high
- rx_data_o  out  DW  last correctly framed word
- rx_valid_o  out  1  one-cycle pulse; rx_data_o updated this cycle
- frame_err_o  out  1  one-cycle pulse; stop bit sampled low
- busy_o  out  1  high in START, DATA and STOP

Behaviour:
- Reset is asynchronous, active-low, on rst; clock is clk. All outputs are registered. Reset values:
  - shift_enb_o=0, shift_bit_o=0, hold_o=1, rx_data_o=0, rx_valid_o=0, frame_err_o=0, busy_o=0.
  - Synchronizer flops reset to 1. State resets to IDLE. Counters reset to 0.
- Synchronizer: 2-flop chain to produce rx_s, plus a previous-value flop. A falling edge is rx_s=0 with prev=1. Input-to-rx_s latency is 2 cycles.
- baud_cnt counts 0..BIT_TICKS-1. Its width is $clog2(BIT_TICKS). It clears on every state change.
- bit_cnt has width $clog2(DW+1).
- State machine:
  - IDLE: on a falling edge with en_i=1, go to START and set baud_cnt=0.
  - START: when baud_cnt=BIT_TICKS/2-1, sample rx_s.
    - rx_s=0: go to DATA and set bit_cnt=0.
    - rx_s=1: glitch; return to IDLE with no outputs.
  - DATA: when baud_cnt=BIT_TICKS-1, pulse shift_enb_o for one cycle with shift_bit_o=rx_s, and increment bit_cnt. After the DW-th pulse, go to STOP.
  - STOP: when baud_cnt=BIT_TICKS-1, sample rx_s.
    - rx_s=1: rx_data_o<=data_i, pulse rx_valid_o, go to IDLE.
    - rx_s=0: pulse frame_err_o, leave rx_data_o unchanged, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a false start on a held-low line.
- hold_o is 0 only in DATA and 1 in all other states, so the shift register contents are frozen between frames. shift_enb_o is never asserted while hold_o=1.
- Sampling points are the centre of each bit, ±1 clk. Frame latency is the start edge plus 2 sync cycles plus (DW+1.5)·BIT_TICKS cycles to the rx_valid_o pulse.
- Back-to-back frames: the falling edge of the next start bit is accepted on the first IDLE cycle. No idle gap is required beyond the stop bit.
- en_i=0 in any state: synchronous return to IDLE on the next edge. No valid or error pulse is produced, and partial data is discarded; hold_o=1.
- rx_valid_o and frame_err_o are mutually exclusive and never high in consecutive cycles from the same frame.
- Asynchronous reset mid-frame: immediate return to reset values; the next frame starts clean.

Decomposition:
- UART_pkg contains:
  - DW and the data word type.
  - The one-bit type.
  - The rx state enum: IDLE, START, DATA, STOP, BREAK.
  - The BIT_TICKS default constant.
  - A packed struct for the controller's registered outputs.
- One natural sub-module, uart_baud_cnt: parameterized modulo counter with clear input, and terminal-count and half-count flags.

Test Plan:
- BIT_TICKS=16, send 0x55 with a valid stop bit -> exactly 8 shift_enb_o pulses 16 cycles apart, bits 1,0,1,0,1,0,1,0 in order; rx_valid_o pulse with rx_data_o=0x55; frame_err_o stays 0.
- rx_i low for 5 cycles (less than half a bit) in IDLE -> returns to IDLE; no shift_enb_o; busy_o back to 0; hold_o stays 1.
- Send 0xA3 with stop bit 0, line held low 40 cycles -> frame_err_o pulses once; rx_data_o keeps its previous value; no new frame until rx_i returns high.
- Back-to-back 0xA3 then 0x0F with no idle gap -> two rx_valid_o pulses with data 0xA3 then 0x0F, spaced 10·BIT_TICKS ±1 cycles.
- Assert rst after the 4th data bit of 0xFF -> all outputs at reset values immediately; the following 0x3C frame is received correctly.
- Drop en_i during DATA -> IDLE next cycle with hold_o=1; no rx_valid_o or frame_err_o; restore en_i and send 0x81 -> rx_data_o=0x81.
